page_reg_writer: RTL and testbench
==================================

# page_reg_writer

Write-side sequencer for the 4x4 DMA page register file. It accepts CPU I/O writes to the page ports, maps each port to a register slot, and drives the file's `d`, `wa`, `wb` and `write` pins. Each write strobe has programmable setup, pulse and hold phases, so the register file captures stable data. A 2-entry buffer absorbs back-to-back OUT instructions. The DMA controller drives the read side (`ra`, `rb`, `read`) of the same file independently.

## Interface
- `SETUP_CYCLES`, 1: cycles that address/data are stable before `write` rises (≥1).
- `STROBE_CYCLES`, 2: cycles that `write` stays high (≥1).
- `HOLD_CYCLES`, 1: cycles that address/data are held after `write` falls (≥1).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous reset, active-low.
- `io_wr`  in  1  one-cycle write request from the I/O decode.
- `io_addr`  in  4  low nibble of the port address.
- `io_data`  in  4  page bits A19..A16.
- `io_ready`  out  1  high when the buffer can take a request; it equals the buffer-not-full flag.
- `unmapped`  out  1  one-cycle pulse, high the cycle after an accepted request whose address is not a page port.
- `d`  out  4  data to the register file.
- `wa`, `wb`  out  1 each  write slot select, where slot = {wb,wa}.
- `write`  out  1  active-high write enable to the register file.

## Operation
- **Address map** (io_addr → slot):
  - 0x7 → 0 (ch0)
  - 0x3 → 1 (ch1)
  - 0x1 → 2 (ch2)
  - 0x2 → 3 (ch3)
  - Any other value is unmapped.
- **Accept:** a request is accepted when `io_wr` && `io_ready` at a clock edge.
  - A mapped request pushes {slot, data} into the buffer.
  - An unmapped request is not pushed; it only pulses `unmapped`.
  - `io_wr` while `!io_ready` is dropped silently. The requester is responsible for honouring `io_ready`.
- **Buffer:** FIFO, depth 2, in-order, with registered full/empty flags.
  - A push and a pop in the same cycle are both performed.
  - When the buffer is full, `io_ready` is 0 even if a pop happens that cycle, because full is registered.
- **FSM states:** IDLE, SETUP, STROBE, HOLD, with one down-counter shared by all phases.
  - IDLE: if the buffer is not empty, pop the head into the output registers (`d`, `wa`, `wb`), load the counter with SETUP_CYCLES, and go to SETUP. Otherwise stay.
  - SETUP: `write`=0. When the counter expires, go to STROBE and load STROBE_CYCLES.
  - STROBE: `write`=1. When the counter expires, go to HOLD and load HOLD_CYCLES.
  - HOLD: `write`=0 with `d`/`wa`/`wb` unchanged. When the counter expires, return to IDLE.
- **Output registers:** `d`, `wa` and `wb` change only at the pop edge and keep their last values in IDLE. Between pops they never glitch.
- **Back-to-back writes:** every write passes through one IDLE cycle, so there is a 1-cycle gap between transactions.

## Timing
- **Reset:** synchronous. Every output and all state are reset to the values below, regardless of the current phase:
  - `d`=0, `wa`=0, `wb`=0, `write`=0, `unmapped`=0
  - buffer empty, so `io_ready`=1
  - FSM state IDLE
- **Reset mid-STROBE:** `write` drops at the reset edge. A truncated write is acceptable.
- **Single-write latency**, with the request accepted at edge 0, the buffer empty and the FSM in IDLE:
  - Entry is visible in the buffer after edge 0.
  - Pop at edge 1; outputs are valid from edge 1.
  - `write` is high from edge 1+S to edge 1+S+P, where S = SETUP_CYCLES and P = STROBE_CYCLES.
  - FSM returns to IDLE at edge 1+S+P+H, where H = HOLD_CYCLES.
  - With default parameters: `write` is high for edges 2–4 (two cycles) and the FSM is IDLE again at edge 5.
- **Throughput:** one write every S+P+H+1 cycles, which is 5 cycles with default parameters.
- **Unmapped pulse:** `unmapped` is registered and is high exactly one cycle, starting at the edge after acceptance.

## Structure
- **Package `page_reg_pkg`:**
  - state enum {IDLE, SETUP, STROBE, HOLD}
  - port-to-slot constants (0x7, 0x3, 0x1, 0x2)
  - slot and data width constants (2 and 4)
  - a mapping function from io_addr to {valid, slot}
- **Sub-module `pr_fifo`:** 2-entry, 6-bit-wide synchronous FIFO with push, pop, full and empty, using the same reset.
- The FSM, counter and output registers live in the top level.

## Test plan
1. **Reset values.** Hold `reset_n`=0 for 3 cycles → all outputs 0 and `io_ready`=1. Release reset.
2. **Single write.** Write addr 0x3, data 0xA → at edge 1 `d`=0xA and {wb,wa}=01; `write` high for exactly 2 cycles starting at edge 2; a behavioural register-file model then reads 0xA at slot 1.
3. **Buffering.** Write 0x7/0x1, 0x1/0x2 and 0x2/0x3 on consecutive cycles:
   - `io_ready` drops after the second push, and the third request is dropped.
   - Slots 0 and 2 are written in order, with 1 IDLE cycle between the strobes; slot 3 is unchanged.
4. **Unmapped address.** Write addr 0x5, data 0xF → `unmapped` is high for 1 cycle and no `write` pulse occurs.
5. **Reset mid-operation.** Assert `reset_n`=0 during STROBE → `write`=0 at the next edge, the buffer is emptied, and a new write after release completes normally.
6. **Parameter sweep.** S=2, P=3, H=2 → `write` high for 3 cycles; `d` is stable for 2 cycles before and 2 cycles after the pulse; throughput is 8 cycles per write.

Source files
------------

// File: rtl/page_reg_pkg.sv
// page_reg_pkg: shared types, port map and mapping helper for the page register writer.
package page_reg_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;
  localparam int SLOT_W = 2;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] PORT_CH0 = 4'h7;
  localparam logic [ADDR_W-1:0] PORT_CH1 = 4'h3;
  localparam logic [ADDR_W-1:0] PORT_CH2 = 4'h1;
  localparam logic [ADDR_W-1:0] PORT_CH3 = 4'h2;
  // Returns {valid, slot}; valid is 0 for addresses that are not page ports.
  function automatic logic [SLOT_W:0] map_port(input logic [ADDR_W-1:0] addr);
    return addr == PORT_CH0 ? {1'b1, 2'd0} :
           addr == PORT_CH1 ? {1'b1, 2'd1} :
           addr == PORT_CH2 ? {1'b1, 2'd2} :
           addr == PORT_CH3 ? {1'b1, 2'd3} : '0;
  endfunction
endpackage

// File: rtl/page_reg_writer_fifo.sv
// pr_fifo: 2-entry synchronous FIFO with registered full/empty flags.
module pr_fifo #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic wp_q, wp_d, rp_q, rp_d, full_q, full_d, empty_q, empty_d;
  logic [1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !full_q;
    do_pop = pop && !empty_q;
    mem_d = mem_q;
    mem_d[wp_q] = do_push ? din : mem_q[wp_q];
    wp_d = wp_q ^ do_push;
    rp_d = rp_q ^ do_pop;
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    full_d = cnt_d == 2'd2;
    empty_d = cnt_d == 2'd0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      empty_q <= empty_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign dout = mem_q[rp_q];
  assign full = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/page_reg_writer.sv
// page_reg_writer: buffers CPU page-port writes and sequences setup/strobe/hold write cycles.
module page_reg_writer
  import page_reg_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              io_wr,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_data,
  output logic              io_ready,
  output logic              unmapped,
  output logic [DATA_W-1:0] d,
  output logic              wa,
  output logic              wb,
  output logic              write
);
  localparam int CW = 8;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic unmapped_q, unmapped_d;
  logic [SLOT_W:0] map;
  logic [SLOT_W+DATA_W-1:0] head;
  logic full, empty, accept, pop, expired;
  assign map = map_port(io_addr);
  assign accept = io_wr && !full;
  pr_fifo #(.W(SLOT_W + DATA_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept && map[SLOT_W]),
    .pop     (pop),
    .din     ({map[SLOT_W-1:0], io_data}),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );
  // One shared down-counter times every phase; a phase ends when it reads 1.
  always_comb begin
    expired = cnt_q == CW'(1);
    pop = state_q == IDLE && !empty;
    unmapped_d = accept && !map[SLOT_W];
    d_d = pop ? head[DATA_W-1:0] : d_q;
    slot_d = pop ? head[SLOT_W+DATA_W-1:DATA_W] : slot_q;
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = pop ? SETUP : IDLE;
        cnt_d = pop ? CW'(SETUP_CYCLES) : cnt_q;
      end
      SETUP: begin
        state_d = expired ? STROBE : SETUP;
        cnt_d = expired ? CW'(STROBE_CYCLES) : cnt_q - CW'(1);
      end
      STROBE: begin
        state_d = expired ? HOLD : STROBE;
        cnt_d = expired ? CW'(HOLD_CYCLES) : cnt_q - CW'(1);
      end
      HOLD: begin
        state_d = expired ? IDLE : HOLD;
        cnt_d = cnt_q - CW'(1);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      d_q <= '0;
      slot_q <= '0;
      unmapped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      d_q <= d_d;
      slot_q <= slot_d;
      unmapped_q <= unmapped_d;
    end
  end
  assign io_ready = !full;
  assign unmapped = unmapped_q;
  assign d = d_q;
  assign {wb, wa} = slot_q;
  assign write = state_q == STROBE;
endmodule

// File: tb/tb_page_reg_writer.sv
// tb_page_reg_writer: default and slow-timing instances checked against a transaction-level model.
module tb_page_reg_writer;
  logic clk = 0, reset_n = 0, io_wr = 0;
  logic [3:0] io_addr = 0, io_data = 0;
  logic [1:0] rdy, unm, wa, wb, wr;
  logic [3:0] dd [2];
  int checks = 0, errors = 0, cyc = 0;
  int S [2] = '{1, 2};
  int P [2] = '{2, 3};
  int H [2] = '{1, 2};
  logic [5:0] mq [2][2];
  int mn [2] = '{0, 0};
  int t [2] = '{0, 0};
  bit busy [2] = '{0, 0};
  logic [3:0] ed [2] = '{0, 0};
  logic [1:0] es [2] = '{0, 0};
  bit eu [2] = '{0, 0};
  bit ew [2] = '{0, 0};
  logic [3:0] rf [2][4];
  int rises [2] = '{0, 0};
  int last_rise [2] = '{0, 0};
  int prev_rise [2] = '{0, 0};
  int unm_cnt [2] = '{0, 0};
  bit wr_prev [2] = '{0, 0};
  int sl, n0;
  bit acc;

  always #5 clk = ~clk;

  page_reg_writer dut0 (
    .clk(clk), .reset_n(reset_n), .io_wr(io_wr), .io_addr(io_addr), .io_data(io_data),
    .io_ready(rdy[0]), .unmapped(unm[0]), .d(dd[0]), .wa(wa[0]), .wb(wb[0]), .write(wr[0])
  );
  page_reg_writer #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .io_wr(io_wr), .io_addr(io_addr), .io_data(io_data),
    .io_ready(rdy[1]), .unmapped(unm[1]), .d(dd[1]), .wa(wa[1]), .wb(wb[1]), .write(wr[1])
  );

  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'h7: return 0;
      4'h3: return 1;
      4'h1: return 2;
      4'h2: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction model: a queue of pending writes and a clock of edges since the pop.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        mn[i] = 0; busy[i] = 0; t[i] = 0; ed[i] = 0; es[i] = 0; eu[i] = 0;
      end else begin
        n0 = mn[i];
        acc = io_wr && n0 < 2;
        if (busy[i]) begin
          t[i]++;
          if (t[i] == S[i] + P[i] + H[i]) busy[i] = 0;
        end else if (n0 > 0) begin
          es[i] = mq[i][0][5:4];
          ed[i] = mq[i][0][3:0];
          mq[i][0] = mq[i][1];
          mn[i]--;
          busy[i] = 1;
          t[i] = 0;
        end
        sl = slot_of(io_addr);
        if (acc && sl >= 0) begin
          mq[i][mn[i]] = {sl[1:0], io_data};
          mn[i]++;
        end
        eu[i] = acc && sl < 0;
      end
      ew[i] = busy[i] && t[i] >= S[i] && t[i] < S[i] + P[i];
    end
  end

  always @(negedge clk) begin
    if (cyc > 0)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("io_ready[%0d]", i), rdy[i], mn[i] < 2);
        chk($sformatf("unmapped[%0d]", i), unm[i], eu[i]);
        chk($sformatf("d[%0d]", i), dd[i], ed[i]);
        chk($sformatf("slot[%0d]", i), {wb[i], wa[i]}, es[i]);
        chk($sformatf("write[%0d]", i), wr[i], ew[i]);
      end
  end

  // External register file and pulse bookkeeping, driven from the DUT pins.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr[i]) rf[i][{wb[i], wa[i]}] = dd[i];
      if (wr[i] && !wr_prev[i]) begin
        prev_rise[i] = last_rise[i];
        last_rise[i] = cyc;
        rises[i]++;
      end
      wr_prev[i] = wr[i];
      if (unm[i]) unm_cnt[i]++;
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1] && mn[0] == 0 && mn[1] == 0) return;
    end
    errors++;
    $display("FAIL idle_timeout: got busy expected idle within 80 cycles");
  endtask

  task automatic put(input logic [3:0] a, input logic [3:0] v);
    io_wr = 1; io_addr = a; io_data = v;
    @(negedge clk);
  endtask

  initial begin
    int n [2];
    int first [2];
    int r [2];
    int u [2];
    for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) rf[i][j] = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy[0], 1);
    chk("rst_write", wr[0], 0);
    chk("rst_d", dd[0], 0);
    chk("rst_unmapped", unm[0], 0);
    chk("rst_slot", {wb[1], wa[1]}, 0);
    reset_n = 1;
    @(negedge clk);

    put(4'h3, 4'hA);
    io_wr = 0;
    n = '{0, 0};
    first = '{-1, -1};
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("single_d", dd[0], 4'hA);
        chk("single_slot", {wb[0], wa[0]}, 1);
      end
      for (int i = 0; i < 2; i++)
        if (wr[i]) begin
          n[i]++;
          if (first[i] < 0) first[i] = k;
        end
      if (k == 1 || k == 2 || k == 6 || k == 7) begin
        chk("sweep_d_stable", dd[1], 4'hA);
        chk("sweep_write_low", wr[1], 0);
      end
    end
    chk("single_pulse_len", n[0], 2);
    chk("single_pulse_start", first[0], 2);
    chk("sweep_pulse_len", n[1], 3);
    chk("sweep_pulse_start", first[1], 3);
    wait_idle();
    chk("single_rf1", rf[0][1], 4'hA);
    chk("sweep_rf1", rf[1][1], 4'hA);

    put(4'h3, 4'h5);
    put(4'h7, 4'h1);
    put(4'h1, 4'h2);
    chk("buf_ready0", rdy[0], 0);
    chk("buf_ready1", rdy[1], 0);
    put(4'h2, 4'h3);
    io_wr = 0;
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("buf_rf0[%0d]", i), rf[i][0], 4'h1);
      chk($sformatf("buf_rf2[%0d]", i), rf[i][2], 4'h2);
      chk($sformatf("buf_rf3[%0d]", i), rf[i][3], 4'h0);
    end
    chk("throughput_default", last_rise[0] - prev_rise[0], 5);
    chk("throughput_sweep", last_rise[1] - prev_rise[1], 8);

    r = rises;
    u = unm_cnt;
    put(4'h5, 4'hF);
    io_wr = 0;
    chk("unm_pulse0", unm[0], 1);
    chk("unm_pulse1", unm[1], 1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("unm_count[%0d]", i), unm_cnt[i] - u[i], 1);
      chk($sformatf("unm_no_write[%0d]", i), rises[i] - r[i], 0);
    end

    put(4'h2, 4'h6);
    put(4'h7, 4'h9);
    io_wr = 0;
    begin
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = wr[0];
      end
      if (!seen) begin
        errors++;
        $display("FAIL strobe_timeout: got no write expected write within 20 cycles");
      end
    end
    reset_n = 0;
    @(negedge clk);
    chk("rst_mid_write", wr[0], 0);
    chk("rst_mid_ready0", rdy[0], 1);
    chk("rst_mid_ready1", rdy[1], 1);
    reset_n = 1;
    r = rises;
    repeat (10) @(negedge clk);
    chk("rst_flush0", rises[0] - r[0], 0);
    chk("rst_flush1", rises[1] - r[1], 0);
    chk("rst_rf0_kept", rf[0][0], 4'h1);
    put(4'h1, 4'h4);
    io_wr = 0;
    wait_idle();
    chk("rst_after_rf2_0", rf[0][2], 4'h4);
    chk("rst_after_rf2_1", rf[1][2], 4'h4);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
